// File: rtl/fst_io_pkg.sv
// Shared widths, debounce lengths and types for the fst input-conditioning path.
package fst_io_pkg;

    localparam int unsigned FST_IN_WIDTH        = 16;
    localparam int unsigned DEBOUNCE_CYCLES_HW  = 50000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

    typedef logic [FST_IN_WIDTH-1:0] fst_word_t;

    // COUNT: candidate is settling; DONE: candidate accepted, counter saturated.
    typedef enum logic {
        ST_COUNT = 1'b0,
        ST_DONE  = 1'b1
    } deb_state_e;

endpackage

// File: rtl/fst_sync2.sv
// Two-flop synchroniser for asynchronous inputs, synchronous active-high reset.
module fst_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;

    // Back-to-back flops, no logic between stages.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/fst_in_debounce.sv
// Synchronises and debounces the DIP-switch word and step button as one vector.
module fst_in_debounce
    import fst_io_pkg::*;
#(
    parameter int unsigned WIDTH         = FST_IN_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_HW
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] sw_raw,
    input  logic             btn_raw,
    output logic [WIDTH-1:0] dat_out,
    output logic             changed,
    output logic             btn_level,
    output logic             btn_pulse,
    output logic             busy
);

    localparam int unsigned VW    = WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [VW-1:0]    v_raw;
    logic [VW-1:0]    sync_q;
    logic [VW-1:0]    cand_q, cand_d;
    logic [VW-1:0]    commit_q, commit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    deb_state_e       state_q, state_d;
    logic             changed_d, pulse_d;

    assign v_raw = {btn_raw, sw_raw};

    fst_sync2 #(
        .W (VW)
    ) u_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d        (v_raw),
        .q        (sync_q)
    );

    // State, candidate, counter, committed value and pulse registers.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= ST_COUNT;
            cand_q    <= '0;
            cnt_q     <= '0;
            commit_q  <= '0;
            changed   <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            commit_q  <= commit_d;
            changed   <= changed_d;
            btn_pulse <= pulse_d;
        end
    end

    // Next state: restart on any new sample, count while settling, commit once.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        commit_d  = commit_q;
        changed_d = 1'b0;
        pulse_d   = 1'b0;
        if (sync_q != cand_q) begin
            cand_d  = sync_q;
            cnt_d   = '0;
            state_d = ST_COUNT;
        end else if (state_q == ST_COUNT) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = ST_DONE;
                commit_d  = cand_q;
                changed_d = (cand_q[WIDTH-1:0] != commit_q[WIDTH-1:0]);
                pulse_d   = cand_q[WIDTH] & ~commit_q[WIDTH];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign dat_out   = commit_q[WIDTH-1:0];
    assign btn_level = commit_q[WIDTH];

    // Settling indicator: a new sample is pending or the candidate is not yet committed.
    assign busy = (sync_q != cand_q) | (cand_q != commit_q);

endmodule

// File: doc/fst_in_debounce.md
Name: fst_in_debounce

Overview:
- Upstream input-conditioning stage for the fst core.
- Takes the raw 16-bit DIP-switch word and the raw "step/exec" push button, which are asynchronous and bouncy.
- Synchronises both, debounces them as one vector, and drives the core's in_dat with a stable word.
- Also produces single-cycle change/button pulses the core or a display block may consume.

Parameters:
- WIDTH, 16: width of the switch word (matches the core's in_dat).
- STABLE_CYCLES, 50000: consecutive identical synchronised samples required before a new value is accepted. Must be >= 1.
- CNT_W, $clog2(STABLE_CYCLES+1): counter width. Derived; never overridden.

Ports:
- clk_in  input  1  system clock, same domain as the fst core.
- reset_in  input  1  synchronous reset, active-high.
- sw_raw  input  WIDTH  raw asynchronous switch word.
- btn_raw  input  1  raw asynchronous push button, 1 = pressed.
- dat_out  output  WIDTH  debounced switch word; connects to the core's in_dat.
- changed  output  1  one-cycle pulse when dat_out takes a new value.
- btn_level  output  1  debounced button level.
- btn_pulse  output  1  one-cycle pulse on the debounced 0->1 edge of the button.
- busy  output  1  high while a candidate value differs from the committed value or is still settling.

Behaviour:
- Internal vector v = {btn_raw, sw_raw}, width WIDTH+1. Switch bits and button are debounced together with one counter.
- Synchroniser: two flops, sync1 <= v, then sync2 <= sync1. No logic between the stages.
- Candidate register cand and counter cnt, updated on every clk_in edge:
  - If sync2 != cand: cand <= sync2 and cnt <= 0 (restart).
  - Else if cnt == STABLE_CYCLES-1: commit. If cand != committed value, committed <= cand. cnt holds (saturates) and does not wrap.
  - Otherwise cnt <= cnt+1.
- Committed register = {btn_level, dat_out}.
- changed: 1 for exactly the cycle after a commit that altered dat_out bits. A button-only change does not assert changed.
- btn_pulse: 1 for exactly the cycle after a commit in which btn_level went 0->1. Never asserted on 1->0.
- busy: combinational, = (sync2 != cand) | (cand != committed).
- Latency:
  - Raw input changes before edge 0 and then holds. The committed value updates at edge STABLE_CYCLES+2, and the pulse is visible in the following cycle.
  - Example: STABLE_CYCLES=1 updates at edge 3.
- Bounce: any sync2 change before the count completes restarts the count from 0. A glitch shorter than STABLE_CYCLES is never committed.
- Return to the committed value mid-count: no commit occurs and no pulse is generated. busy drops once cand == committed.
- Simultaneous switch and button change: a single commit, with changed and btn_pulse asserted in the same cycle.
- Reset:
  - reset_in high at any edge clears sync1, sync2, cand, cnt, dat_out, btn_level, changed and btn_pulse to 0. This includes reset mid-count.
  - Reset wins over all other updates.
  - After release, if inputs are already nonzero, the full latency applies before dat_out reflects them.
- Outputs dat_out, btn_level, changed and btn_pulse are all registered (no combinational path from inputs). busy is the only combinational output.

Decomposition:
- Package fst_io_pkg holds:
  - FST_IN_WIDTH = 16
  - DEBOUNCE_CYCLES_HW = 50000
  - DEBOUNCE_CYCLES_SIM = 4
  - typedef logic [FST_IN_WIDTH-1:0] fst_word_t
- One sub-module, fst_sync2: a parameterised-width two-flop synchroniser with synchronous active-high reset, instantiated once for the WIDTH+1 vector.
- Debounce FSM, counter and edge detection live in the top module.

Test Plan (STABLE_CYCLES=4, WIDTH=16):
- Reset, then set sw_raw=16'h1234 before edge 0 and hold -> dat_out=16'h1234 after edge 6; changed high one cycle only; busy high during edges 0..5, then low.
- sw_raw bounces 16'h00FF/16'h0000 every 2 cycles for 20 cycles, then holds 16'h00FF -> no commit during the bounce; dat_out=16'h00FF exactly 6 edges after the last transition; exactly one changed pulse.
- btn_raw pulsed high for 3 cycles -> btn_level stays 0, btn_pulse never asserts. btn_raw held high for 10 cycles -> one btn_pulse, btn_level=1. Release -> btn_level returns to 0, no btn_pulse, no changed.
- sw_raw=16'hA5A5 and btn_raw=1 changed together -> single commit edge, with changed and btn_pulse high in the same cycle.
- Committed 16'h0001; sw_raw -> 16'h0002 for 2 cycles, then back to 16'h0001 -> no commit, no changed, busy returns low.
- Committed 16'hBEEF; sw_raw -> 16'h0F0F; reset_in asserted mid-count -> all outputs 0 next edge. After release, with 16'h0F0F still held, dat_out=16'h0F0F at edge 6 after release.
